// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencing controller.
package multdiv_pkg;

    localparam int MD_WIDTH      = 32;
    localparam int MD_MULT_STEPS = MD_WIDTH / 2;
    localparam int MD_DIV_STEPS  = MD_WIDTH;
    localparam int MD_CNT_W      = $clog2(MD_DIV_STEPS + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MULT = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

    // The datapath is occupied from operand load until the last iteration.
    function automatic logic state_is_busy(input md_state_e st);
        logic b;
        case (st)
            ST_LOAD: b = 1'b1;
            ST_MULT: b = 1'b1;
            ST_DIV:  b = 1'b1;
            default: b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/booth_step_decode.sv
// Radix-4 Booth digit decode of {q[1], q[0], q[-1]} into datapath selects.
module booth_step_decode
    import multdiv_pkg::*;
(
    input  logic       enable,
    input  logic [2:0] booth_bits,
    output logic       booth_same,
    output logic       booth_sub,
    output logic       booth_double
);

    // Digit 0 -> same, negative digit -> subtract, magnitude 2 -> double.
    always_comb begin
        booth_same   = 1'b0;
        booth_sub    = 1'b0;
        booth_double = 1'b0;
        if (enable) begin
            case (booth_bits)
                3'b000: booth_same = 1'b1;
                3'b001: booth_same = 1'b0;
                3'b010: booth_same = 1'b0;
                3'b011: booth_double = 1'b1;
                3'b100: begin
                    booth_sub    = 1'b1;
                    booth_double = 1'b1;
                end
                3'b101: booth_sub = 1'b1;
                3'b110: booth_sub = 1'b1;
                3'b111: booth_same = 1'b1;
                default: begin
                    booth_same   = 1'b0;
                    booth_sub    = 1'b0;
                    booth_double = 1'b0;
                end
            endcase
        end else begin
            booth_same   = 1'b0;
            booth_sub    = 1'b0;
            booth_double = 1'b0;
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Control sequencer for the shared radix-4 Booth multiply / restoring divide
// datapath. Holds only control state; all operand data lives in the datapath.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int WIDTH      = MD_WIDTH,
    parameter int MULT_STEPS = WIDTH / 2,
    parameter int DIV_STEPS  = WIDTH
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             ctrl_MULT,
    input  logic                             ctrl_DIV,
    input  logic [2:0]                       booth_bits,
    input  logic                             divisor_zero,
    input  logic                             remainder_neg,
    input  logic                             mult_overflow,
    output logic                             load,
    output logic                             step_en,
    output logic                             booth_same,
    output logic                             booth_sub,
    output logic                             booth_double,
    output logic                             div_restore,
    output logic                             quotient_bit,
    output logic                             is_div,
    output logic                             busy,
    output logic [$clog2(DIV_STEPS+1)-1:0]   step_count,
    output logic                             data_resultRDY,
    output logic                             data_exception
);

    localparam int CNT_W = $clog2(DIV_STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 32'sd1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 32'sd1);

    md_state_e        state_r;
    md_state_e        state_s;
    logic             is_div_r;
    logic             dz_flag_r;
    logic [CNT_W-1:0] step_count_r;
    logic             start_s;
    logic             in_mult_s;
    logic             in_div_s;

    assign start_s   = ctrl_MULT | ctrl_DIV;
    assign in_mult_s = (state_r == ST_MULT);
    assign in_div_s  = (state_r == ST_DIV);

    // Any start pulse restarts at LOAD; otherwise walk the operation phases.
    always_comb begin
        state_s = state_r;
        if (start_s) begin
            state_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_IDLE: state_s = ST_IDLE;
                ST_LOAD: begin
                    if (is_div_r && divisor_zero) begin
                        state_s = ST_DONE;
                    end else if (is_div_r) begin
                        state_s = ST_DIV;
                    end else begin
                        state_s = ST_MULT;
                    end
                end
                ST_MULT: begin
                    if (step_count_r == MULT_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_MULT;
                    end
                end
                ST_DIV: begin
                    if (step_count_r == DIV_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_DIV;
                    end
                end
                ST_DONE: state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Phase register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operation type is captured on an accepted start; multiply has priority.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            is_div_r <= 1'b0;
        end else if (start_s) begin
            is_div_r <= ctrl_DIV & ~ctrl_MULT;
        end else begin
            is_div_r <= is_div_r;
        end
    end

    // Divide-by-zero flag: cleared entering LOAD, set when LOAD sees a zero divisor.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dz_flag_r <= 1'b0;
        end else if (state_s == ST_LOAD) begin
            dz_flag_r <= 1'b0;
        end else if ((state_r == ST_LOAD) && is_div_r && divisor_zero) begin
            dz_flag_r <= 1'b1;
        end else begin
            dz_flag_r <= dz_flag_r;
        end
    end

    // Iteration counter: zero during LOAD, counts completed steps, holds after.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_count_r <= CNT_ZERO;
        end else if (state_s == ST_LOAD) begin
            step_count_r <= CNT_ZERO;
        end else if (in_mult_s || in_div_s) begin
            step_count_r <= step_count_r + CNT_ONE;
        end else begin
            step_count_r <= step_count_r;
        end
    end

    booth_step_decode u_booth_step_decode (
        .enable       (in_mult_s),
        .booth_bits   (booth_bits),
        .booth_same   (booth_same),
        .booth_sub    (booth_sub),
        .booth_double (booth_double)
    );

    // Control strobes decoded from the phase register; divide strobes only in DIV.
    always_comb begin
        load           = (state_r == ST_LOAD);
        step_en        = in_mult_s | in_div_s;
        busy           = state_is_busy(state_r);
        div_restore    = in_div_s & remainder_neg;
        quotient_bit   = in_div_s & ~remainder_neg;
        is_div         = is_div_r;
        step_count     = step_count_r;
        data_resultRDY = (state_r == ST_DONE);
        if (state_r == ST_DONE) begin
            data_exception = is_div_r ? dz_flag_r : mult_overflow;
        end else begin
            data_exception = 1'b0;
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench: timeline-based reference model of the sequencer.
module tb_multdiv_sequencer;

    localparam int MS = 16;
    localparam int DS = 32;

    localparam int OP_NONE = 0;
    localparam int OP_MULT = 1;
    localparam int OP_DIV  = 2;
    localparam int OP_DZ   = 3;

    logic       clock;
    logic       reset_n;
    logic       ctrl_MULT;
    logic       ctrl_DIV;
    logic [2:0] booth_bits;
    logic       divisor_zero;
    logic       remainder_neg;
    logic       mult_overflow;
    logic       load;
    logic       step_en;
    logic       booth_same;
    logic       booth_sub;
    logic       booth_double;
    logic       div_restore;
    logic       quotient_bit;
    logic       is_div;
    logic       busy;
    logic [5:0] step_count;
    logic       data_resultRDY;
    logic       data_exception;

    int errors = 0;
    int checks = 0;

    // reference model state: operation kind, cycle index since the start edge
    int   m_op;
    int   m_t;
    int   m_cnt;
    logic m_isdiv;

    multdiv_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .booth_bits     (booth_bits),
        .divisor_zero   (divisor_zero),
        .remainder_neg  (remainder_neg),
        .mult_overflow  (mult_overflow),
        .load           (load),
        .step_en        (step_en),
        .booth_same     (booth_same),
        .booth_sub      (booth_sub),
        .booth_double   (booth_double),
        .div_restore    (div_restore),
        .quotient_bit   (quotient_bit),
        .is_div         (is_div),
        .busy           (busy),
        .step_count     (step_count),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Booth digit value d = -2*q1 + q0 + q-1 determines the operation.
    function automatic logic [2:0] booth_ref(input logic [2:0] b);
        int d;
        d = -2 * int'(b[2]) + int'(b[1]) + int'(b[0]);
        return {d == 0, d < 0, (d == 2) || (d == -2)};
    endfunction

    function automatic logic [16:0] observed();
        return {load, step_en, booth_same, booth_sub, booth_double, div_restore,
                quotient_bit, is_div, busy, step_count, data_resultRDY, data_exception};
    endfunction

    function automatic logic [16:0] expected();
        logic ld, se, bsm, bsb, bdb, dr, qb, by, rdy, ex;
        int   cnt;
        ld = 1'b0; se = 1'b0; bsm = 1'b0; bsb = 1'b0; bdb = 1'b0;
        dr = 1'b0; qb = 1'b0; by = 1'b0; rdy = 1'b0; ex = 1'b0;
        cnt = m_cnt;
        if (m_op != OP_NONE) begin
            if (m_t == 1) begin
                ld = 1'b1; by = 1'b1; cnt = 0;
            end else if (m_op == OP_MULT && m_t <= MS + 1) begin
                se = 1'b1; by = 1'b1; cnt = m_t - 2;
                {bsm, bsb, bdb} = booth_ref(booth_bits);
            end else if (m_op == OP_DIV && m_t <= DS + 1) begin
                se = 1'b1; by = 1'b1; cnt = m_t - 2;
                dr = remainder_neg; qb = ~remainder_neg;
            end else begin
                rdy = 1'b1;
                ex  = (m_op == OP_MULT) ? mult_overflow : (m_op == OP_DZ);
                cnt = (m_op == OP_MULT) ? MS : (m_op == OP_DIV) ? DS : 0;
            end
        end
        return {ld, se, bsm, bsb, bdb, dr, qb, m_isdiv, by, 6'(cnt), rdy, ex};
    endfunction

    task automatic model_reset();
        m_op = OP_NONE; m_t = 0; m_cnt = 0; m_isdiv = 1'b0;
    endtask

    // Advance the reference model across one rising edge with the current inputs.
    task automatic model_edge();
        int end_t;
        if (ctrl_MULT || ctrl_DIV) begin
            m_op = ctrl_MULT ? OP_MULT : OP_DIV;
            m_isdiv = ~ctrl_MULT;
            m_t = 1;
        end else if (m_op != OP_NONE) begin
            if (m_t == 1 && m_op == OP_DIV && divisor_zero) m_op = OP_DZ;
            end_t = (m_op == OP_MULT) ? MS + 2 : (m_op == OP_DIV) ? DS + 2 : 2;
            if (m_t == end_t) begin
                m_cnt = (m_op == OP_MULT) ? MS : (m_op == OP_DIV) ? DS : 0;
                m_op = OP_NONE;
            end else begin
                m_t = m_t + 1;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [16:0] got;
        logic [16:0] exp;
        got = observed();
        exp = expected();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive after the falling edge, check, then clock the model.
    task automatic cycle(input logic m, input logic d, input logic [2:0] bb,
                         input logic dz, input logic rn, input logic ov, input string tag);
        ctrl_MULT = m; ctrl_DIV = d; booth_bits = bb;
        divisor_zero = dz; remainder_neg = rn; mult_overflow = ov;
        #1;
        check(tag);
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        reset_n = 1'b0;
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; booth_bits = 3'b000;
        divisor_zero = 1'b0; remainder_neg = 1'b0; mult_overflow = 1'b0;
        model_reset();
        @(negedge clock);
        #1 check("reset_state");
        @(negedge clock);
        reset_n = 1'b1;
        idle(2, "idle_after_reset");

        // multiply, Booth bits 100 throughout
        cycle(1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, "mult_start");
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, "mult_b100");

        // divide, alternating trial remainder sign
        cycle(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, "div_start");
        for (int i = 0; i < 36; i++)
            cycle(1'b0, 1'b0, 3'b000, 1'b0, 1'(i % 2), 1'b0, "div_alt");

        // divide by zero
        cycle(1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, "dz_start");
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, "dz_run");

        // both starts high, overflow asserted: multiply with exception
        cycle(1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 1'b1, "both_start");
        for (int i = 0; i < 20; i++)
            cycle(1'b0, 1'b0, 3'($urandom), 1'b0, 1'b0, 1'b1, "mult_ovf");

        // divide start re-pulsed at step 10 of a multiply
        cycle(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, "abort_mult_start");
        for (int i = 0; i < 10; i++)
            cycle(1'b0, 1'b0, 3'($urandom), 1'b0, 1'b0, 1'b0, "abort_mult_run");
        cycle(1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, "abort_repulse");
        for (int i = 0; i < 36; i++)
            cycle(1'b0, 1'b0, 3'b000, 1'b0, 1'($urandom), 1'b0, "abort_div_run");

        // start landing in DONE
        cycle(1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, "done_start_mult");
        for (int i = 0; i < 17; i++)
            cycle(1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, "done_start_run");
        cycle(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, "start_in_done");
        for (int i = 0; i < 36; i++)
            cycle(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, "after_done_div");

        // asynchronous reset at step 5 of a divide
        cycle(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, "rst_div_start");
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, "rst_div_run");
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; remainder_neg = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("async_reset_mid_div");
        @(negedge clock);
        #1 check("reset_held");
        @(negedge clock);
        reset_n = 1'b1;
        idle(3, "idle_after_midreset");

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = int'($urandom_range(0, 39));
            cycle((r == 0) || (r == 2), (r == 1) || (r == 2), 3'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), "random");
        end
        idle(40, "final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
